// File: rtl/hybrid_adder8_if.sv
// Operand/result bundle for the 8-bit hybrid adder.
// The master drives operands and reads the registered sum and carry-out.
interface hybrid_adder8_if;
    logic [7:0] X;
    logic [7:0] Y;
    logic       C0;
    logic [7:0] S;
    logic       C8;

    modport master (output X, output Y, output C0, input S, input C8);
    modport slave  (input X, input Y, input C0, output S, output C8);
endinterface

// File: rtl/hybrid_adder8.sv
// 8-bit adder: 2-bit ripple / 4-bit lookahead / 2-bit ripple, registered {C8,S}.
// Latency 1 cycle; no backpressure, a new operand set is accepted every cycle.
module hybrid_adder8 (
    input  logic            clk,
    input  logic            rst_n,
    hybrid_adder8_if.slave  bus
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic [7:0] sum;
    logic [7:0] s_q;
    logic       c8_q;

    assign g = bus.X & bus.Y;
    assign p = bus.X ^ bus.Y;

    // Low ripple slice, bits 1:0
    assign c[0]   = bus.C0;
    assign c[1]   = g[0] | (c[0] & p[0]);
    assign c[2]   = g[1] | (c[1] & p[1]);
    assign sum[0] = p[0] ^ c[0];
    assign sum[1] = p[1] ^ c[1];

    // Lookahead slice, bits 5:2: every carry expanded directly from c[2]
    assign c[3] = g[2]
                | (p[2] & c[2]);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & c[2]);
    assign c[5] = g[4]
                | (p[4] & g[3])
                | (p[4] & p[3] & g[2])
                | (p[4] & p[3] & p[2] & c[2]);
    assign c[6] = g[5]
                | (p[5] & g[4])
                | (p[5] & p[4] & g[3])
                | (p[5] & p[4] & p[3] & g[2])
                | (p[5] & p[4] & p[3] & p[2] & c[2]);
    assign sum[5:2] = p[5:2] ^ c[5:2];

    // High ripple slice, bits 7:6
    assign c[7]   = g[6] | (c[6] & p[6]);
    assign c[8]   = g[7] | (c[7] & p[7]);
    assign sum[6] = p[6] ^ c[6];
    assign sum[7] = p[7] ^ c[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= 8'h00;
            c8_q <= 1'b0;
        end else begin
            s_q  <= sum;
            c8_q <= c[8];
        end
    end

    assign bus.S  = s_q;
    assign bus.C8 = c8_q;

endmodule

// File: tb/tb_hybrid_adder8.sv
// Directed and randomized checks of hybrid_adder8 against plain X+Y+C0 arithmetic.
module tb_hybrid_adder8;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hybrid_adder8_if bus ();

    hybrid_adder8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed={C8,S}=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return 9'(total % 512);
    endfunction

    // Drive operands on the falling edge, check one rising edge later.
    task automatic apply(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic [8:0] exp);
        @(negedge clk);
        bus.X  = x;
        bus.Y  = y;
        bus.C0 = c;
        @(posedge clk);
        #1;
        check(tag, {bus.C8, bus.S}, exp);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        logic       rc;

        rst_n  = 1'b0;
        bus.X  = 8'hFF;
        bus.Y  = 8'hFF;
        bus.C0 = 1'b1;
        #1;
        check("reset_initial", {bus.C8, bus.S}, 9'h000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", {bus.C8, bus.S}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        apply("plan_60_7f", 8'h60, 8'h7F, 1'b0, 9'h0DF);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_midcycle", {bus.C8, bus.S}, 9'h000);
        @(negedge clk);
        bus.X  = 8'hFF;
        bus.Y  = 8'hFE;
        bus.C0 = 1'b0;
        @(posedge clk);
        #1;
        check("reset_discards_pending", {bus.C8, bus.S}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        apply("plan_ff_fe",     8'hFF, 8'hFE, 1'b0, 9'h1FD);
        apply("propagate_only", 8'hAA, 8'h55, 1'b0, 9'h0FF);
        apply("plan_08_81_c0",  8'h08, 8'h81, 1'b0, 9'h089);
        apply("plan_08_81_c1",  8'h08, 8'h81, 1'b1, 9'h08A);
        apply("plan_01_00_c1",  8'h01, 8'h00, 1'b1, 9'h002);
        apply("plan_f0_88_c1",  8'hF0, 8'h88, 1'b1, 9'h179);
        apply("full_propagate", 8'hAA, 8'h55, 1'b1, 9'h100);
        apply("gen_low_to_c8",  8'h03, 8'hFD, 1'b0, 9'h100);
        apply("gen_b1_thru_cla", 8'h02, 8'h3E, 1'b0, 9'h040);
        apply("all_zero",       8'h00, 8'h00, 1'b0, 9'h000);
        apply("all_ones_c1",    8'hFF, 8'hFF, 1'b1, 9'h1FF);

        for (int i = 0; i < 16; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            apply("random", rx, ry, rc, ref_sum(rx, ry, rc));
        end

        // Every X and carry-in against a strided set of Y values (includes 0 and 0xFF).
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 256; yi += 5) begin
                for (int ci = 0; ci < 2; ci++) begin
                    apply("sweep", 8'(xi), 8'(yi), 1'(ci), ref_sum(8'(xi), 8'(yi), 1'(ci)));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
